mem_access_stage: RTL

//  MEM stage of the 5-stage pipeline, between the EX/MEM register and writeback.
//  - Turns the EX/MEM fields into byte-lane data-memory transactions over a req/ack handshake.
//  - Raises stall while an access is outstanding.
//  - Sign/zero-extends load data and registers the MEM/WB fields.

---
 rtl/mem_access_stage.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM fields -> byte-lane dm req/ack, load extend, MEM/WB register; non-mem 1 cycle, mem op >= 3 cycles.
// Backpressure: stall held while an access is in flight; MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_ALUOUT,
    input  logic [31:0] mem_RFRD2,
    input  logic [4:0]  mem_RegisterRd,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        mem_MemtoReg,
    input  logic        mem_RegWrite,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_RegisterRd,
    output logic        wb_RegWrite,
    output logic        bus_err,
    output logic        misalign
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [1:0]  sz_q, sz_d, off_q, off_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] wb_inst_q, wb_inst_d, wb_result_q, wb_result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d, bus_err_q, bus_err_d, misalign_q, misalign_d;

    logic        mem_op, trap, tmo;
    logic [1:0]  sz, a_raw, a;
    logic        sgn;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ld_ext;

    // Access decode: size, signedness, lane offset and lane data
    always_comb begin
        mem_op = mem_MemRead | mem_MemWrite;
        a_raw  = mem_ALUOUT[1:0];
        sz     = SZ_W;
        sgn    = 1'b0;
        case (mem_inst[31:26])
            OP_LB:   begin sz = SZ_B; sgn = 1'b1; end
            OP_LBU:  sz = SZ_B;
            OP_LH:   begin sz = SZ_H; sgn = 1'b1; end
            OP_LHU:  sz = SZ_H;
            OP_SB:   sz = SZ_B;
            OP_SH:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem_op & (((sz == SZ_H) & a_raw[0]) | ((sz == SZ_W) & (a_raw != 2'b00)));
`else
        trap = 1'b0;
`endif
        case (sz)
            SZ_B:    a = a_raw;
            SZ_H:    a = {a_raw[1], 1'b0};
            default: a = 2'b00;
        endcase
        be_n    = 4'b1111;
        wdata_n = 32'h0;
        if (mem_MemWrite) begin
            case (sz)
                SZ_B:    begin be_n = 4'b0001 << a; wdata_n = {4{mem_RFRD2[7:0]}}; end
                SZ_H:    begin be_n = a[1] ? 4'b1100 : 4'b0011; wdata_n = {2{mem_RFRD2[15:0]}}; end
                default: wdata_n = mem_RFRD2;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    rbyte = dm_rdata[7:0];
            2'd1:    rbyte = dm_rdata[15:8];
            2'd2:    rbyte = dm_rdata[23:16];
            default: rbyte = dm_rdata[31:24];
        endcase
        rhalf = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (sz_q)
            SZ_B:    ld_ext = {{24{sgn_q & rbyte[7]}}, rbyte};
            SZ_H:    ld_ext = {{16{sgn_q & rhalf[15]}}, rhalf};
            default: ld_ext = dm_rdata;
        endcase
    end

    assign tmo   = (state_q == S_ACCESS) && (cnt_q == TMO_LAST) && !dm_ack;
    assign stall = !rst && (((state_q == S_IDLE) && mem_op && !trap) || (state_q == S_ACCESS));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mem_op && !trap) state_d = S_ACCESS;
            S_ACCESS: if (dm_ack || tmo) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // MEM/WB defaults to a bubble; only non-stalled cycles load real fields
    always_comb begin
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        sz_d        = sz_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        hold_d      = hold_q;
        cnt_d       = 8'd0;
        wb_inst_d   = 32'h0;
        wb_result_d = 32'h0;
        wb_rd_d     = 5'd0;
        wb_rw_d     = 1'b0;
        bus_err_d   = tmo;
        misalign_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    wb_inst_d  = mem_inst;
                    misalign_d = 1'b1;
                end else if (mem_op) begin
                    dm_req_d   = 1'b1;
                    dm_we_d    = mem_MemWrite;
                    dm_addr_d  = {mem_ALUOUT[31:2], 2'b00};
                    dm_be_d    = be_n;
                    dm_wdata_d = wdata_n;
                    sz_d       = sz;
                    sgn_d      = sgn;
                    off_d      = a;
                    hold_d     = 32'h0;
                end else begin
                    wb_inst_d   = mem_inst;
                    wb_result_d = mem_ALUOUT;
                    wb_rd_d     = mem_RegisterRd;
                    wb_rw_d     = mem_RegWrite;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (dm_ack || tmo) begin
                    dm_req_d   = 1'b0;
                    dm_we_d    = 1'b0;
                    dm_addr_d  = 32'h0;
                    dm_be_d    = 4'h0;
                    dm_wdata_d = 32'h0;
                end
                if (dm_ack) hold_d = ld_ext;
            end
            S_DONE: begin
                // bus_err_q is high here exactly when the access timed out
                wb_inst_d   = mem_inst;
                wb_result_d = mem_MemtoReg ? hold_q : mem_ALUOUT;
                wb_rd_d     = mem_RegisterRd;
                wb_rw_d     = mem_RegWrite & ~bus_err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= 32'h0;
            dm_be_q     <= 4'h0;
            dm_wdata_q  <= 32'h0;
            sz_q        <= SZ_W;
            sgn_q       <= 1'b0;
            off_q       <= 2'b00;
            hold_q      <= 32'h0;
            wb_inst_q   <= 32'h0;
            wb_result_q <= 32'h0;
            wb_rd_q     <= 5'd0;
            wb_rw_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            sz_q        <= sz_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            hold_q      <= hold_d;
            wb_inst_q   <= wb_inst_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign dm_req        = dm_req_q;
    assign dm_we         = dm_we_q;
    assign dm_addr       = dm_addr_q;
    assign dm_be         = dm_be_q;
    assign dm_wdata      = dm_wdata_q;
    assign wb_inst       = wb_inst_q;
    assign wb_result     = wb_result_q;
    assign wb_RegisterRd = wb_rd_q;
    assign wb_RegWrite   = wb_rw_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;
endmodule
